// File: rtl/fetch_instruction_queue_super.sv
// fetch_instruction_queue_super
//   3-wide instruction buffer between the superscalar fetch stage (with its
//   jump controller) and decode/rename. Accepts up to three fetched
//   instructions per cycle and presents the oldest three in program order.
//   A flush discards everything that is buffered.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-low reset
//   flush_i          discard all entries (highest priority)
//   in_valid_k       fetch lane k valid (k = 0..2, lane 0 oldest)
//   in_pc_k          fetch lane k PC
//   in_instr_k       fetch lane k instruction
//   in_taken_k       fetch lane k predicted-taken flag
//   fetch_ready_o    at least three free entries (registered occupancy)
//   out_valid_k      k-th oldest entry valid
//   out_pc_k         k-th oldest entry PC
//   out_instr_k      k-th oldest entry instruction
//   out_taken_k      k-th oldest entry predicted-taken flag
//   dequeue_count_i  entries consumed by decode this cycle (0..3)
//   occupancy_o      number of valid entries (0..DEPTH)

module fetch_instruction_queue_super #(
    parameter int size  = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,

    input  logic                     in_valid_0,
    input  logic                     in_valid_1,
    input  logic                     in_valid_2,
    input  logic [size-1:0]          in_pc_0,
    input  logic [size-1:0]          in_pc_1,
    input  logic [size-1:0]          in_pc_2,
    input  logic [size-1:0]          in_instr_0,
    input  logic [size-1:0]          in_instr_1,
    input  logic [size-1:0]          in_instr_2,
    input  logic                     in_taken_0,
    input  logic                     in_taken_1,
    input  logic                     in_taken_2,

    output logic                     fetch_ready_o,

    output logic                     out_valid_0,
    output logic                     out_valid_1,
    output logic                     out_valid_2,
    output logic [size-1:0]          out_pc_0,
    output logic [size-1:0]          out_pc_1,
    output logic [size-1:0]          out_pc_2,
    output logic [size-1:0]          out_instr_0,
    output logic [size-1:0]          out_instr_1,
    output logic [size-1:0]          out_instr_2,
    output logic                     out_taken_0,
    output logic                     out_taken_1,
    output logic                     out_taken_2,

    input  logic [1:0]               dequeue_count_i,
    output logic [$clog2(DEPTH):0]   occupancy_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LANES = 3;

    typedef struct packed {
        logic [size-1:0] pc;
        logic [size-1:0] instr;
        logic            taken;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           lane_in  [LANES];
    entry_t           lane_out [LANES];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   occupancy;
    logic             fetch_ready;
    logic [1:0]       enq_cnt;
    logic [1:0]       deq_eff;

    // Lane packing keeps the write loop uniform across the three lanes.
    always_comb begin
        lane_in[0] = '{pc: in_pc_0, instr: in_instr_0, taken: in_taken_0};
        lane_in[1] = '{pc: in_pc_1, instr: in_instr_1, taken: in_taken_1};
        lane_in[2] = '{pc: in_pc_2, instr: in_instr_2, taken: in_taken_2};
    end

    // Room for a whole 3-lane group, judged on registered occupancy only so
    // a same-cycle dequeue never opens the gate.
    assign fetch_ready = (occupancy <= (PTR_W+1)'(DEPTH - LANES));

    // Lanes are accepted contiguously from lane 0; the first invalid lane
    // truncates the group.
    always_comb begin
        enq_cnt = '0;
        if (fetch_ready && !flush_i && in_valid_0) begin
            enq_cnt = 2'd1;
            if (in_valid_1) begin
                enq_cnt = 2'd2;
                if (in_valid_2) begin
                    enq_cnt = 2'd3;
                end
            end
        end
    end

    // Requests beyond what is buffered are clipped. When clipping occurs,
    // occupancy is below 3 so its low two bits hold the full value.
    always_comb begin
        deq_eff = dequeue_count_i;
        if (occupancy < (PTR_W+1)'(dequeue_count_i)) begin
            deq_eff = occupancy[1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else if (flush_i) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            head      <= head + PTR_W'(deq_eff);
            tail      <= tail + PTR_W'(enq_cnt);
            occupancy <= occupancy + (PTR_W+1)'(enq_cnt) - (PTR_W+1)'(deq_eff);
        end
    end

    // Storage is deliberately not reset; validity is carried by occupancy.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < LANES; k++) begin
            if (k < 32'(enq_cnt)) begin
                mem[tail + PTR_W'(k)] <= lane_in[k];
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < LANES; k++) begin
            lane_out[k] = mem[head + PTR_W'(k)];
        end
    end

    assign fetch_ready_o = fetch_ready;
    assign occupancy_o   = occupancy;

    assign out_valid_0 = (occupancy > (PTR_W+1)'(0));
    assign out_valid_1 = (occupancy > (PTR_W+1)'(1));
    assign out_valid_2 = (occupancy > (PTR_W+1)'(2));

    assign out_pc_0    = lane_out[0].pc;
    assign out_pc_1    = lane_out[1].pc;
    assign out_pc_2    = lane_out[2].pc;
    assign out_instr_0 = lane_out[0].instr;
    assign out_instr_1 = lane_out[1].instr;
    assign out_instr_2 = lane_out[2].instr;
    assign out_taken_0 = lane_out[0].taken;
    assign out_taken_1 = lane_out[1].taken;
    assign out_taken_2 = lane_out[2].taken;

endmodule

// File: tb/tb_fetch_instruction_queue_super.sv
module tb_fetch_instruction_queue_super;

    localparam int SZ    = 32;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush_i;
    logic            in_valid_0, in_valid_1, in_valid_2;
    logic [SZ-1:0]   in_pc_0, in_pc_1, in_pc_2;
    logic [SZ-1:0]   in_instr_0, in_instr_1, in_instr_2;
    logic            in_taken_0, in_taken_1, in_taken_2;
    logic            fetch_ready_o;
    logic            out_valid_0, out_valid_1, out_valid_2;
    logic [SZ-1:0]   out_pc_0, out_pc_1, out_pc_2;
    logic [SZ-1:0]   out_instr_0, out_instr_1, out_instr_2;
    logic            out_taken_0, out_taken_1, out_taken_2;
    logic [1:0]      dequeue_count_i;
    logic [3:0]      occupancy_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [SZ-1:0] pc;
        logic [SZ-1:0] instr;
        logic          taken;
    } ent_t;

    ent_t q[$];

    fetch_instruction_queue_super #(.size(SZ), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush_i        (flush_i),
        .in_valid_0     (in_valid_0),
        .in_valid_1     (in_valid_1),
        .in_valid_2     (in_valid_2),
        .in_pc_0        (in_pc_0),
        .in_pc_1        (in_pc_1),
        .in_pc_2        (in_pc_2),
        .in_instr_0     (in_instr_0),
        .in_instr_1     (in_instr_1),
        .in_instr_2     (in_instr_2),
        .in_taken_0     (in_taken_0),
        .in_taken_1     (in_taken_1),
        .in_taken_2     (in_taken_2),
        .fetch_ready_o  (fetch_ready_o),
        .out_valid_0    (out_valid_0),
        .out_valid_1    (out_valid_1),
        .out_valid_2    (out_valid_2),
        .out_pc_0       (out_pc_0),
        .out_pc_1       (out_pc_1),
        .out_pc_2       (out_pc_2),
        .out_instr_0    (out_instr_0),
        .out_instr_1    (out_instr_1),
        .out_instr_2    (out_instr_2),
        .out_taken_0    (out_taken_0),
        .out_taken_1    (out_taken_1),
        .out_taken_2    (out_taken_2),
        .dequeue_count_i(dequeue_count_i),
        .occupancy_o    (occupancy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic v0, input logic v1, input logic v2,
                          input logic [SZ-1:0] base, input logic [2:0] tk,
                          input logic [1:0] dq, input logic fl);
        in_valid_0 = v0;  in_valid_1 = v1;  in_valid_2 = v2;
        in_pc_0 = base;   in_pc_1 = base + 4;  in_pc_2 = base + 8;
        in_instr_0 = base ^ 32'hA5A5_0000;
        in_instr_1 = (base + 4) ^ 32'hA5A5_0000;
        in_instr_2 = (base + 8) ^ 32'hA5A5_0000;
        in_taken_0 = tk[0]; in_taken_1 = tk[1]; in_taken_2 = tk[2];
        dequeue_count_i = dq;
        flush_i = fl;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 1'b0, '0, 3'b000, 2'd0, 1'b0);
    endtask

    // Model: the queue is a plain FIFO of entries; compare its front three.
    task automatic compare_model();
        logic          ov [3];
        logic [SZ-1:0] op [3];
        logic [SZ-1:0] oi [3];
        logic          ot [3];
        ov = '{out_valid_0, out_valid_1, out_valid_2};
        op = '{out_pc_0, out_pc_1, out_pc_2};
        oi = '{out_instr_0, out_instr_1, out_instr_2};
        ot = '{out_taken_0, out_taken_1, out_taken_2};
        check("occupancy", 64'(occupancy_o), 64'(q.size()));
        check("fetch_ready", 64'(fetch_ready_o), 64'((DEPTH - q.size()) >= 3));
        for (int k = 0; k < 3; k++) begin
            check($sformatf("out_valid_%0d", k), 64'(ov[k]), 64'(q.size() > k));
            if (q.size() > k) begin
                check($sformatf("out_pc_%0d", k),    64'(op[k]), 64'(q[k].pc));
                check($sformatf("out_instr_%0d", k), 64'(oi[k]), 64'(q[k].instr));
                check($sformatf("out_taken_%0d", k), 64'(ot[k]), 64'(q[k].taken));
            end
        end
    endtask

    task automatic update_model();
        int  sz;
        int  d;
        bit  ready;
        sz    = q.size();
        ready = (DEPTH - sz) >= 3;
        if (flush_i) begin
            q.delete();
        end else begin
            d = int'(dequeue_count_i);
            if (d > sz) d = sz;
            repeat (d) void'(q.pop_front());
            if (ready && in_valid_0) begin
                q.push_back('{in_pc_0, in_instr_0, in_taken_0});
                if (in_valid_1) begin
                    q.push_back('{in_pc_1, in_instr_1, in_taken_1});
                    if (in_valid_2) q.push_back('{in_pc_2, in_instr_2, in_taken_2});
                end
            end
        end
    endtask

    // Inputs are set just after a rising edge; outputs are compared on the
    // falling edge; the model advances on the rising edge.
    task automatic cycle();
        @(negedge clk);
        compare_model();
        @(posedge clk);
        update_model();
        #1;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        #1;
        check("rst_occupancy", 64'(occupancy_o), 64'd0);
        check("rst_fetch_ready", 64'(fetch_ready_o), 64'd1);
        check("rst_out_valid", 64'({out_valid_2, out_valid_1, out_valid_0}), 64'b000);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // First group, lane 1 predicted taken.
        set_in(1'b1, 1'b1, 1'b1, 32'h100, 3'b010, 2'd0, 1'b0);
        cycle();
        check("t1_out_valid", 64'({out_valid_2, out_valid_1, out_valid_0}), 64'b111);
        check("t1_pc0", 64'(out_pc_0), 64'h100);
        check("t1_pc1", 64'(out_pc_1), 64'h104);
        check("t1_pc2", 64'(out_pc_2), 64'h108);
        check("t1_taken", 64'({out_taken_2, out_taken_1, out_taken_0}), 64'b010);
        check("t1_occupancy", 64'(occupancy_o), 64'd3);

        // Fill to 6; third group must be refused.
        set_in(1'b1, 1'b1, 1'b1, 32'h10C, 3'b000, 2'd0, 1'b0);
        cycle();
        check("t2_occupancy6", 64'(occupancy_o), 64'd6);
        check("t2_ready_low", 64'(fetch_ready_o), 64'd0);
        set_in(1'b1, 1'b1, 1'b1, 32'h118, 3'b111, 2'd0, 1'b0);
        cycle();
        check("t2_refused", 64'(occupancy_o), 64'd6);

        // Drain to move head to 6, then refill across the 7->0 wrap.
        set_in(1'b0, 1'b0, 1'b0, '0, 3'b000, 2'd3, 1'b0);
        cycle();
        check("t3_pc0_after_deq", 64'(out_pc_0), 64'h10C);
        cycle();
        check("t3_empty", 64'(occupancy_o), 64'd0);
        set_in(1'b1, 1'b1, 1'b1, 32'h300, 3'b100, 2'd0, 1'b0);
        cycle();
        set_in(1'b1, 1'b1, 1'b1, 32'h30C, 3'b001, 2'd0, 1'b0);
        cycle();
        check("t3_occ6", 64'(occupancy_o), 64'd6);
        check("t3_wrap_pc0", 64'(out_pc_0), 64'h300);
        check("t3_wrap_pc2", 64'(out_pc_2), 64'h308);
        set_in(1'b0, 1'b0, 1'b0, '0, 3'b000, 2'd3, 1'b0);
        cycle();
        check("t3_wrap_pc0b", 64'(out_pc_0), 64'h30C);
        check("t3_wrap_pc1b", 64'(out_pc_1), 64'h310);
        check("t3_wrap_pc2b", 64'(out_pc_2), 64'h314);
        cycle();
        check("t3_drained", 64'(occupancy_o), 64'd0);

        // Non-contiguous lanes, then an over-sized dequeue.
        set_in(1'b1, 1'b0, 1'b1, 32'h200, 3'b000, 2'd0, 1'b0);
        cycle();
        check("t4_occ1", 64'(occupancy_o), 64'd1);
        check("t4_pc0", 64'(out_pc_0), 64'h200);
        check("t4_valid", 64'({out_valid_2, out_valid_1, out_valid_0}), 64'b001);
        set_in(1'b1, 1'b0, 1'b0, 32'h210, 3'b001, 2'd0, 1'b0);
        cycle();
        set_in(1'b0, 1'b0, 1'b0, '0, 3'b000, 2'd3, 1'b0);
        cycle();
        check("t4_overdeq", 64'(occupancy_o), 64'd0);
        set_in(1'b1, 1'b1, 1'b0, 32'h220, 3'b010, 2'd1, 1'b0);
        cycle();
        check("t4_after_pc0", 64'(out_pc_0), 64'h220);

        // Flush wins over same-cycle enqueue and dequeue.
        set_in(1'b1, 1'b1, 1'b0, 32'h400, 3'b000, 2'd0, 1'b0);
        cycle();
        check("t5_occ4", 64'(occupancy_o), 64'd4);
        set_in(1'b1, 1'b1, 1'b1, 32'h500, 3'b111, 2'd2, 1'b1);
        cycle();
        check("t5_flush_occ", 64'(occupancy_o), 64'd0);
        check("t5_flush_valid", 64'({out_valid_2, out_valid_1, out_valid_0}), 64'b000);
        check("t5_flush_ready", 64'(fetch_ready_o), 64'd1);

        // Steady state: three in, three out each cycle.
        set_in(1'b1, 1'b1, 1'b1, 32'h1000, 3'b000, 2'd0, 1'b0);
        cycle();
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, 1'b1, 1'b1, 32'h1000 + 32'(12 * (i + 1)), 3'(i), 2'd3, 1'b0);
            cycle();
            check($sformatf("t6_occ_%0d", i), 64'(occupancy_o), 64'd3);
            check($sformatf("t6_pc0_%0d", i), 64'(out_pc_0), 64'(32'h1000 + 32'(12 * (i + 1))));
        end

        // Asynchronous reset mid-operation clears immediately.
        idle();
        reset = 1'b0;
        #2;
        check("t7_async_occ", 64'(occupancy_o), 64'd0);
        check("t7_async_valid", 64'({out_valid_2, out_valid_1, out_valid_0}), 64'b000);
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        set_in(1'b1, 1'b1, 1'b1, 32'h700, 3'b101, 2'd0, 1'b0);
        cycle();
        check("t7_post_pc0", 64'(out_pc_0), 64'h700);
        idle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_instruction_queue_super.md
Name: fetch_instruction_queue_super

Overview:
- 3-wide instruction buffer placed directly downstream of the superscalar fetch stage and its jump controller.
- Captures up to 3 fetched instructions per cycle, each with its PC and predicted-taken flag, and presents the oldest 3 in program order to decode/rename.
- Decouples fetch from decode back-pressure and discards all buffered contents on a pipeline flush (misprediction redirect).

Parameters:
- size, 32, width of PC and instruction fields
- DEPTH, 8, number of entries; power of 2, minimum 4
- PTR_W, $clog2(DEPTH), head/tail pointer width (derived, not overridden)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- flush_i  input  1  discard all entries; highest priority
- in_valid_0 / in_valid_1 / in_valid_2  input  1 each  fetch lane valid
- in_pc_0 / in_pc_1 / in_pc_2  input  size each  lane PC
- in_instr_0 / in_instr_1 / in_instr_2  input  size each  lane instruction
- in_taken_0 / in_taken_1 / in_taken_2  input  1 each  predicted jump/taken flag from jump controller
- fetch_ready_o  output  1  queue can accept a full 3-lane group this cycle
- out_valid_0 / out_valid_1 / out_valid_2  output  1 each  oldest, 2nd-oldest and 3rd-oldest entries valid
- out_pc_0 / out_pc_1 / out_pc_2  output  size each  entry PC
- out_instr_0 / out_instr_1 / out_instr_2  output  size each  entry instruction
- out_taken_0 / out_taken_1 / out_taken_2  output  1 each  entry predicted-taken flag
- dequeue_count_i  input  2  number of entries decode consumes this cycle (0..3)
- occupancy_o  output  PTR_W+1  current number of valid entries

Behaviour:
- Reset (asynchronous, reset=0): head=0, tail=0, occupancy=0, all out_valid_k=0, fetch_ready_o=1. Entry storage is not reset; out_pc/out_instr/out_taken are don't-care while invalid. Reset asserted mid-operation discards all contents immediately.
- fetch_ready_o = (DEPTH - occupancy >= 3). Computed from registered occupancy only; a same-cycle dequeue does not raise it.
- Enqueue is all-or-nothing per cycle and occurs only when fetch_ready_o=1 and flush_i=0.
- Lanes are taken contiguously from lane 0. Lanes at and after the first deasserted in_valid are dropped. Example: valid=101 enqueues lane 0 only.
- Enqueued lanes are written at tail, tail+1, tail+2 (mod DEPTH), in lane order. tail advances by the enqueue count.
- Outputs are combinational from storage and registered occupancy: out_valid_k = (occupancy > k); out_*_k = entry[(head+k) mod DEPTH].
- Latency: an entry enqueued in cycle N appears on the outputs in cycle N+1 at the earliest. There is no bypass.
- Dequeue: effective count = min(dequeue_count_i, occupancy). head advances by the effective count. Excess requests are ignored and must not corrupt pointers.
- Simultaneous enqueue and dequeue: occupancy_next = occupancy + enq - deq_eff. Both operations are applied in the same edge. This cannot overflow because the enqueue was gated by free >= 3.
- flush_i=1: at the next edge head=0, tail=0, occupancy=0. Any same-cycle enqueue and dequeue are ignored. Outputs become invalid on the cycle after flush. fetch_ready_o is unaffected during the flush cycle itself.
- Pointer arithmetic wraps modulo DEPTH. occupancy ranges 0..DEPTH inclusive, so full and empty are distinguished by occupancy, not by pointer equality.
- Program order is preserved: lane 0 is older than lane 1, which is older than lane 2, and an earlier cycle is older than a later one.

Test Plan:
- Reset then one enqueue of lanes 0-2 (PCs 0x100/0x104/0x108, in_taken_1=1, dequeue_count_i=0) -> the next cycle shows out_valid=111, out_pc=0x100/0x104/0x108, out_taken=010, occupancy_o=3.
- Enqueue 3 entries per cycle with dequeue_count_i=0 (DEPTH=8) -> occupancy goes 3, 6. fetch_ready_o drops to 0 at occupancy 6. The third group is not accepted and occupancy stays 6.
- Occupancy 6 with head=6 (entries straddling the wrap), dequeue 3 then 3 -> output order matches enqueue order across the index 7->0 wrap, and occupancy reaches 0.
- in_valid=101 at PC 0x200 -> only 0x200 is enqueued, occupancy +1. Separately, dequeue_count_i=3 at occupancy 2 -> occupancy 0, head advances by 2.
- Occupancy 4 with flush_i=1, in_valid=111 and dequeue_count_i=2 in the same cycle -> the next cycle shows occupancy 0, out_valid=000, fetch_ready_o=1.
- Steady state: enqueue 3 and dequeue 3 every cycle for 20 cycles -> occupancy stays constant and the sequence of PCs leaving the queue matches the sequence entering it.
